// File: rtl/cond_exec_unit_pkg.sv
// Shared definitions for the condition-execution unit: condition codes,
// flag bit positions, predicated-block FSM states and block descriptor.
package cond_exec_unit_pkg;

    localparam int unsigned FLAG_W = 4;
    localparam int unsigned COND_W = 4;

    // Condition codes; each odd code is the inverse of the even code below it.
    localparam logic [COND_W-1:0] COND_EQ = 4'h0;
    localparam logic [COND_W-1:0] COND_NE = 4'h1;
    localparam logic [COND_W-1:0] COND_CS = 4'h2;
    localparam logic [COND_W-1:0] COND_CC = 4'h3;
    localparam logic [COND_W-1:0] COND_MI = 4'h4;
    localparam logic [COND_W-1:0] COND_PL = 4'h5;
    localparam logic [COND_W-1:0] COND_VS = 4'h6;
    localparam logic [COND_W-1:0] COND_VC = 4'h7;
    localparam logic [COND_W-1:0] COND_HI = 4'h8;
    localparam logic [COND_W-1:0] COND_LS = 4'h9;
    localparam logic [COND_W-1:0] COND_GE = 4'hA;
    localparam logic [COND_W-1:0] COND_LT = 4'hB;
    localparam logic [COND_W-1:0] COND_GT = 4'hC;
    localparam logic [COND_W-1:0] COND_LE = 4'hD;
    localparam logic [COND_W-1:0] COND_AL = 4'hE;
    localparam logic [COND_W-1:0] COND_NV = 4'hF;

    // Bit positions inside the {N,Z,C,V} flag vector.
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic {
        IT_IDLE   = 1'b0,
        IT_ACTIVE = 1'b1
    } it_state_e;

    // Latched predicated-block descriptor.
    typedef struct packed {
        logic [COND_W-1:0] cond;
        logic [3:0]        then_mask;
        logic [1:0]        last;
    } it_blk_t;

endpackage

// File: rtl/cond_exec_unit_cond_eval.sv
// Pure combinational condition-code evaluator.
//   cond  : 4-bit condition code
//   flags : {N,Z,C,V}
//   met   : 1 when the condition holds for the given flags
module cond_eval
    import cond_exec_unit_pkg::*;
(
    input  logic [COND_W-1:0] cond,
    input  logic [FLAG_W-1:0] flags,
    output logic              met
);

    logic n, z, c, v;
    logic base;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    // Evaluate the even code of each pair; bit 0 inverts (so NV = ~AL).
    always_comb begin
        base = 1'b0;
        case (cond & 4'b1110)
            COND_EQ: base = z;
            COND_CS: base = c;
            COND_MI: base = n;
            COND_VS: base = v;
            COND_HI: base = c & ~z;
            COND_GE: base = (n == v);
            COND_GT: base = ~z & (n == v);
            COND_AL: base = 1'b1;
            default: base = 1'b0;
        endcase
    end

    assign met = base ^ cond[0];

endmodule

// File: rtl/cond_exec_unit.sv
// Condition-execution unit: architectural flag register, NUM_CH independent
// single-cycle condition-query channels, and a predicated-block (IT) tracker.
//   flag_we/flag_in        : flag write, bypassed to same-cycle evaluation
//   q_valid/q_cond         : per-channel queries -> r_valid/r_met one cycle later
//   flags_out              : current flag register
//   it_start/it_cond/it_len/it_then/it_adv : predicated-block control
//   it_active/it_pred      : block in progress / predicate of current slot
module cond_exec_unit
    import cond_exec_unit_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned IT_MAX = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flag_we,
    input  logic [FLAG_W-1:0]        flag_in,
    input  logic [NUM_CH-1:0]        q_valid,
    input  logic [COND_W*NUM_CH-1:0] q_cond,
    output logic [NUM_CH-1:0]        r_valid,
    output logic [NUM_CH-1:0]        r_met,
    output logic [FLAG_W-1:0]        flags_out,
    input  logic                     it_start,
    input  logic [COND_W-1:0]        it_cond,
    input  logic [1:0]               it_len,
    input  logic [3:0]               it_then,
    input  logic                     it_adv,
    output logic                     it_active,
    output logic                     it_pred
);

    localparam logic [1:0] LAST_CAP = 2'(IT_MAX - 1);

    logic [FLAG_W-1:0] flags_q;
    logic [FLAG_W-1:0] eff_flags;
    logic [NUM_CH-1:0] q_met;
    logic              it_met;

    it_state_e  state_q, state_d;
    it_blk_t    blk_q, blk_d;
    logic [1:0] slot_q, slot_d;

    // Same-cycle bypass of a retiring flag write.
    assign eff_flags = flag_we ? flag_in : flags_q;
    assign flags_out = flags_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        cond_eval u_q_eval (
            .cond  (q_cond[COND_W*i +: COND_W]),
            .flags (eff_flags),
            .met   (q_met[i])
        );
    end

    cond_eval u_it_eval (
        .cond  (blk_q.cond),
        .flags (eff_flags),
        .met   (it_met)
    );

    // Flag register and query result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
            r_valid <= '0;
            r_met   <= '0;
        end else begin
            if (flag_we) begin
                flags_q <= flag_in;
            end
            r_valid <= q_valid;
            r_met   <= q_valid & q_met;
        end
    end

    // Predicated-block state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IT_IDLE;
            blk_q   <= '0;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            slot_q  <= slot_d;
        end
    end

    // Next-state: a start always (re)opens a block and wins over advance.
    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        slot_d  = slot_q;
        if (it_start) begin
            state_d         = IT_ACTIVE;
            blk_d.cond      = it_cond;
            blk_d.then_mask = it_then;
            blk_d.last      = (it_len > LAST_CAP) ? LAST_CAP : it_len;
            slot_d          = 2'd0;
        end else begin
            case (state_q)
                IT_ACTIVE: begin
                    if (it_adv) begin
                        if (slot_q == blk_q.last) begin
                            state_d = IT_IDLE;
                        end else begin
                            slot_d = slot_q + 2'd1;
                        end
                    end
                end
                default: begin
                    state_d = IT_IDLE;
                end
            endcase
        end
    end

    assign it_active = (state_q == IT_ACTIVE);
    assign it_pred   = (state_q == IT_ACTIVE) ? ~(it_met ^ blk_q.then_mask[slot_q]) : 1'b1;

endmodule

// File: tb/tb_cond_exec_unit.sv
module tb_cond_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flag_we = 1'b0;
    logic [3:0]  flag_in = '0;
    logic [3:0]  q_valid = '0;
    logic [15:0] q_cond = '0;
    logic [3:0]  r_valid, r_met;
    logic [3:0]  flags_out;
    logic        it_start = 1'b0;
    logic [3:0]  it_cond = '0;
    logic [1:0]  it_len = '0;
    logic [3:0]  it_then = '0;
    logic        it_adv = 1'b0;
    logic        it_active, it_pred;

    // Second instance with a short block limit; shares the stimulus.
    logic [0:0]  r_valid2, r_met2;
    logic [3:0]  flags_out2;
    logic        it_active2, it_pred2;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    cond_exec_unit #(.NUM_CH(4), .IT_MAX(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .flag_in(flag_in),
        .q_valid(q_valid), .q_cond(q_cond), .r_valid(r_valid), .r_met(r_met),
        .flags_out(flags_out), .it_start(it_start), .it_cond(it_cond),
        .it_len(it_len), .it_then(it_then), .it_adv(it_adv),
        .it_active(it_active), .it_pred(it_pred)
    );

    cond_exec_unit #(.NUM_CH(1), .IT_MAX(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .flag_in(flag_in),
        .q_valid(q_valid[0:0]), .q_cond(q_cond[3:0]), .r_valid(r_valid2), .r_met(r_met2),
        .flags_out(flags_out2), .it_start(it_start), .it_cond(it_cond),
        .it_len(it_len), .it_then(it_then), .it_adv(it_adv),
        .it_active(it_active2), .it_pred(it_pred2)
    );

    // Reference model state.
    logic [3:0] m_flags;
    logic [3:0] m_rvalid, m_rmet;
    bit         pol [2][4];     // per-slot polarity list of the open block
    int         head [2];
    int         cnt [2];        // 0 = no block open
    logic [3:0] bcond [2];
    int         cap [2] = '{4, 2};
    logic       obs_pred;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic m_pred(input int k, input logic [3:0] eff);
        if (cnt[k] == 0) return 1'b1;
        return cond_ok(bcond[k], eff) == pol[k][head[k]];
    endfunction

    task automatic model_reset();
        m_flags = '0; m_rvalid = '0; m_rmet = '0;
        for (int k = 0; k < 2; k++) begin
            cnt[k] = 0; head[k] = 0;
        end
    endtask

    // One clock: check combinational outputs mid-cycle, then registered ones after the edge.
    task automatic step();
        logic [3:0] eff;
        logic [3:0] e_rvalid, e_rmet;
        int n;
        @(negedge clk);
        eff = flag_we ? flag_in : m_flags;
        obs_pred = it_pred;
        check("it_pred", 32'(it_pred), 32'(m_pred(0, eff)));
        check("it_pred_short", 32'(it_pred2), 32'(m_pred(1, eff)));
        e_rvalid = q_valid;
        for (int i = 0; i < 4; i++)
            e_rmet[i] = q_valid[i] && cond_ok(q_cond[4*i +: 4], eff);
        @(posedge clk);
        #1;
        if (flag_we) m_flags = flag_in;
        m_rvalid = e_rvalid;
        m_rmet   = e_rmet;
        for (int k = 0; k < 2; k++) begin
            if (it_start) begin
                n = int'(it_len);
                if (n > cap[k] - 1) n = cap[k] - 1;
                cnt[k] = n + 1; head[k] = 0; bcond[k] = it_cond;
                for (int j = 0; j < 4; j++) pol[k][j] = it_then[j];
            end else if (cnt[k] != 0 && it_adv) begin
                head[k]++;
                if (head[k] == cnt[k]) cnt[k] = 0;
            end
        end
        check("r_valid", 32'(r_valid), 32'(m_rvalid));
        check("r_met", 32'(r_met), 32'(m_rmet));
        check("flags_out", 32'(flags_out), 32'(m_flags));
        check("it_active", 32'(it_active), 32'(cnt[0] != 0));
        check("it_active_short", 32'(it_active2), 32'(cnt[1] != 0));
    endtask

    task automatic idle_inputs();
        flag_we = 0; flag_in = '0; q_valid = '0; q_cond = '0;
        it_start = 0; it_cond = '0; it_len = '0; it_then = '0; it_adv = 0;
    endtask

    initial begin
        model_reset();
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("rst_flags", 32'(flags_out), 32'h0);
        check("rst_rvalid", 32'(r_valid), 32'h0);
        check("rst_active", 32'(it_active), 32'h0);
        check("rst_pred", 32'(it_pred), 32'h1);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        // Flag write bypassed into a same-cycle query.
        flag_we = 1; flag_in = 4'b0100; q_valid = 4'b0001; q_cond = 16'h0000;
        step();
        check("bypass_rvalid0", 32'(r_valid[0]), 32'h1);
        check("bypass_rmet0", 32'(r_met[0]), 32'h1);
        check("bypass_flags", 32'(flags_out), 32'h4);

        // Signed comparisons with N and V set.
        flag_we = 1; flag_in = 4'b1001; q_valid = '0;
        step();
        flag_we = 0; q_valid = 4'hF; q_cond = {4'hD, 4'hC, 4'hB, 4'hA};
        step();
        check("signed_rmet", 32'(r_met), 32'b0101);
        q_valid = '0;

        // Block of three slots with mixed polarity.
        flag_we = 1; flag_in = 4'b0000;
        step();
        flag_we = 0; it_start = 1; it_cond = 4'h0; it_len = 2; it_then = 4'b0101;
        step();
        it_start = 0; it_adv = 1;
        step(); check("blk_pred0", 32'(obs_pred), 32'h0);
        step(); check("blk_pred1", 32'(obs_pred), 32'h1);
        step(); check("blk_pred2", 32'(obs_pred), 32'h0);
        check("blk_done", 32'(it_active), 32'h0);
        it_adv = 0;

        // Restart at slot 1 with start and advance together.
        it_start = 1; it_cond = 4'h0; it_len = 3; it_then = 4'h0;
        step();
        it_start = 0; it_adv = 1;
        step();
        it_start = 1; it_adv = 1; it_cond = 4'hE; it_then = 4'b0001; it_len = 0;
        step();
        it_start = 0; it_adv = 0;
        step();
        check("restart_pred", 32'(obs_pred), 32'h1);
        check("restart_active", 32'(it_active), 32'h1);
        it_adv = 1;
        step();
        check("restart_end", 32'(it_active), 32'h0);
        it_adv = 0;

        // Length clamp on the short-limit instance.
        it_start = 1; it_len = 3; it_cond = 4'hE; it_then = 4'hF;
        step();
        it_start = 0; it_adv = 1;
        step(); check("clamp_adv1", 32'(it_active2), 32'h1);
        step(); check("clamp_adv2", 32'(it_active2), 32'h0);
        check("clamp_long_open", 32'(it_active), 32'h1);
        step(); step();
        check("clamp_long_end", 32'(it_active), 32'h0);
        it_adv = 0;

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            flag_we  = ($urandom_range(3) == 0);
            flag_in  = 4'($urandom);
            q_valid  = 4'($urandom);
            q_cond   = 16'($urandom);
            it_start = ($urandom_range(7) == 0);
            it_cond  = 4'($urandom);
            it_len   = 2'($urandom);
            it_then  = 4'($urandom);
            it_adv   = ($urandom_range(1) == 1);
            step();
        end

        // Asynchronous reset in the middle of a block with results pending.
        idle_inputs();
        it_start = 1; it_len = 3; it_cond = 4'hE; it_then = 4'hF;
        step();
        it_start = 0; q_valid = 4'hF; flag_we = 1; flag_in = 4'hB;
        step();
        #2;
        rst_n = 0;
        #1;
        check("async_active", 32'(it_active), 32'h0);
        check("async_rvalid", 32'(r_valid), 32'h0);
        check("async_flags", 32'(flags_out), 32'h0);
        model_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        it_start = 1; it_cond = 4'h1; it_len = 1; it_then = 4'b0011;
        step();
        check("post_rst_start", 32'(it_active), 32'h1);
        it_start = 0; it_adv = 1;
        step(); step();
        it_adv = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cond_exec_unit.md
COND_EXEC_UNIT -- requirements
Module: cond_exec_unit

Interface
REQ-001 Parameter NUM_CH, default 2, number of independent condition-query channels (1..8).
REQ-002 Parameter IT_MAX, default 4, maximum predicated-block length (1..4).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 flag_we  in  1  flag-register write enable (set-flags instruction retiring).
REQ-006 flag_in  in  4  new flags {N,Z,C,V}, bit3=N, bit0=V.
REQ-007 q_valid  in  NUM_CH  per-channel query strobe.
REQ-008 q_cond  in  4*NUM_CH  per-channel condition code; channel i occupies bits [4i+3:4i].
REQ-009 r_valid  out  NUM_CH  per-channel result strobe.
REQ-010 r_met  out  NUM_CH  per-channel condition result.
REQ-011 flags_out  out  4  current architectural flag register {N,Z,C,V}.
REQ-012 it_start  in  1  begin predicated block.
REQ-013 it_cond  in  4  base condition of the block.
REQ-014 it_len  in  2  block length minus one (0 means 1 instruction).
REQ-015 it_then  in  4  bit k=1: slot k uses it_cond; bit k=0: slot k uses its inverse.
REQ-016 it_adv  in  1  one predicated instruction retired.
REQ-017 it_active  out  1  predicated block in progress.
REQ-018 it_pred  out  1  predicate for the current slot (combinational from state and effective flags).

Function
REQ-019 Condition table: 0000 Z; 0001 !Z; 0010 C; 0011 !C; 0100 N; 0101 !N; 0110 V; 0111 !V; 1000 C&!Z; 1001 !C|Z; 1010 N==V; 1011 N!=V; 1100 !Z&(N==V); 1101 Z|(N!=V); 1110 1; 1111 0.
REQ-020 Effective flags = flag_in when flag_we=1, else flags_out (same-cycle bypass).
REQ-021 Flag register loads flag_in on each edge with flag_we=1, else holds.
REQ-022 Query latency exactly 1 cycle: r_valid[i] <= q_valid[i]; r_met[i] <= table(q_cond[i], effective flags) when q_valid[i]=1, else r_met[i] <= 0.
REQ-023 Channels are fully independent; all channels may query in the same cycle with no stall or arbitration.
REQ-024 IT FSM states: IDLE, ACTIVE; registers slot (2 bits), last (2 bits), cond (4 bits), then (4 bits).
REQ-025 IDLE + it_start: latch it_cond/it_then, last=min(it_len, IT_MAX-1), slot=0, go ACTIVE; it_adv in same cycle is ignored.
REQ-026 ACTIVE + it_adv, slot<last: slot increments.
REQ-027 ACTIVE + it_adv, slot==last: return to IDLE.
REQ-028 ACTIVE + it_start (with or without it_adv): restart with new block, slot=0; start wins.
REQ-029 it_pred = table(cond, effective flags) XNOR then[slot] when ACTIVE; it_pred=1 in IDLE.
REQ-030 Inverse of 1110 yields 0; inverse of 1111 yields 1 (no special-casing).
REQ-031 it_active = 1 exactly in ACTIVE.

Reset
REQ-032 rst_n low forces asynchronously: flags_out=0000, r_valid=0, r_met=0, FSM IDLE, slot=0, last=0, cond=0, then=0.
REQ-033 Reset mid-block abandons the block; first post-reset cycle ignores nothing (it_start accepted normally).
REQ-034 Flag writes and queries coincident with reset deassertion edge take effect on the following edge only.

Structure
REQ-035 Shared package holds: condition-code constants (EQ..NV), flag bit-index constants, FSM state typedef.
REQ-036 One sub-module cond_eval (pure combinational table of REQ-019), instantiated NUM_CH+1 times.

Verification
REQ-037 Reset then flag_we=1, flag_in=0100, q_cond0=0000 same cycle -> next cycle r_valid0=1, r_met0=1, flags_out=0100.
REQ-038 flags_out=1001 (N,V set), query codes 1010/1011/1100/1101 on four channels (NUM_CH=4) -> r_met=1,0,1,0.
REQ-039 flags=0000, it_start cond=0000, it_len=2, it_then=0101 -> it_pred 0,1,0 across three it_adv, then it_active=0.
REQ-040 ACTIVE at slot 1, it_start+it_adv same cycle with new cond=1110, it_then=0001 -> slot=0, it_pred=1.
REQ-041 it_len=3 with IT_MAX=2 -> block ends after two it_adv.
REQ-042 rst_n low mid-block with r_valid=1 -> it_active=0, r_valid=0, flags_out=0000 immediately, before next clk edge.
